mux_rr_arbiter_4: RTL and testbench

- Round-robin arbiter that shares one 32-bit 4:1 mux datapath among four requesters.
- Owns the mux select, presents the selected word downstream with a valid/ready handshake, and acknowledges the winning requester on transfer.
- Sits between four producers (e.g. register-file / ALU / memory result sources) and a single shared consumer bus.

---
 rtl/mux_rr_arbiter_4.sv | 101 ++++++++++
 tb/tb_mux_rr_arbiter_4.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter_4.sv
// Round-robin arbiter owning a shared 4:1 WIDTH-bit mux, with a valid/ready
// handshake downstream and a one-hot ack back to the winning requester.
module mux_rr_arbiter_4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       transfer;
  logic [2:0] pick_ptr;
  logic [2:0] pick_next;

  // Returns {found, index} of the first set request scanning start, start+1, ...
  // (mod 4). The loop runs backwards so the smallest offset is assigned last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    case (sel_q)
      2'd0:    out_data = in0;
      2'd1:    out_data = in1;
      2'd2:    out_data = in2;
      default: out_data = in3;
    endcase
  end

  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign transfer  = out_valid && out_ready;
  assign ack       = transfer ? (4'd1 << sel_q) : 4'd0;
  assign sel       = sel_q;
  assign busy      = (state_q == GRANT);

  assign pick_ptr  = rr_pick(req, ptr_q);
  assign pick_next = rr_pick(req, sel_q + 2'd1);

  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_ptr[2]) begin
          sel_d   = pick_ptr[1:0];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
        end else if (out_ready) begin
          // Served requester drops to lowest priority; re-arbitrate without a bubble.
          ptr_d = sel_q + 2'd1;
          if (pick_next[2]) sel_d = pick_next[1:0];
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// Directed, table-driven bench for mux_rr_arbiter_4: each vector is one cycle of
// inputs plus the outputs expected before the next rising edge.
module tb_mux_rr_arbiter_4;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic        e_busy;
    logic [1:0]  e_sel;
    logic        e_valid;
    logic [3:0]  e_ack;
    logic [31:0] e_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, " busy"},      32'(busy),      32'(v.e_busy));
    check({tag, " sel"},       32'(sel),       32'(v.e_sel));
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.e_valid));
    check({tag, " ack"},       32'(ack),       32'(v.e_ack));
    check({tag, " out_data"},  out_data,       v.e_data);
  endtask

  // Drive one cycle's inputs after the falling edge, then sample before the rising edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    req       = v.req;
    out_ready = v.rdy;
    #1;
    check_outs(tag, v);
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic b,
                              input logic [1:0] s, input logic va, input logic [3:0] a,
                              input logic [31:0] d);
    vec_t v;
    v.req = r; v.rdy = rd; v.e_busy = b; v.e_sel = s;
    v.e_valid = va; v.e_ack = a; v.e_data = d;
    return v;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    req       = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check_outs(tag, mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, in0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_data();
    in0 = 32'hAAAA_AAAA;
    in1 = 32'h5555_5555;
    in2 = 32'h0000_0000;
    in3 = 32'hFFFF_FFFF;
  endtask

  vec_t rr_tab[13];

  initial begin
    rst = 1'b1; req = '0; out_ready = 1'b0;
    set_data();
    #12;

    // Reset, single request on 2, then proof that ptr moved to 3.
    do_reset("rst0");
    apply("single c0", mk(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA));
    apply("single c1", mk(4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 32'h0000_0000));
    apply("single c2", mk(4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000, 32'h0000_0000));
    apply("single c3", mk(4'b1111, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 32'h0000_0000));
    apply("ptr3 c4",   mk(4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 32'hFFFF_FFFF));
    // Async reset between edges while sel=3 and busy=1.
    #2;
    rst = 1'b1;
    #1;
    check_outs("async rst", mk(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA));
    @(negedge clk);
    rst = 1'b0;

    // Table: full rotation, withdrawal mid-run, wrap fairness with req=1001.
    rr_tab[0]  = mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA);
    rr_tab[1]  = mk(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 32'hAAAA_AAAA);
    rr_tab[2]  = mk(4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 32'h5555_5555);
    rr_tab[3]  = mk(4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 32'h0000_0000);
    rr_tab[4]  = mk(4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 32'hFFFF_FFFF);
    rr_tab[5]  = mk(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 32'hAAAA_AAAA);
    rr_tab[6]  = mk(4'b1001, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 32'h5555_5555);
    rr_tab[7]  = mk(4'b1001, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000, 32'h5555_5555);
    rr_tab[8]  = mk(4'b1001, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 32'hFFFF_FFFF);
    rr_tab[9]  = mk(4'b1001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 32'hAAAA_AAAA);
    rr_tab[10] = mk(4'b1001, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 32'hFFFF_FFFF);
    rr_tab[11] = mk(4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA);
    rr_tab[12] = mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA);
    do_reset("rst1");
    for (int i = 0; i < 13; i++) apply($sformatf("rr[%0d]", i), rr_tab[i]);

    // Backpressure on requester 1.
    do_reset("rst2");
    in1 = 32'h7777_7777;
    apply("bp c0", mk(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA));
    for (int i = 1; i <= 3; i++)
      apply($sformatf("bp hold%0d", i), mk(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000, 32'h7777_7777));
    apply("bp xfer", mk(4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 32'h7777_7777));
    apply("bp after", mk(4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 32'h7777_7777));
    set_data();

    // Withdrawal on 0: ptr must stay 0, so 0 beats 1 on the next arbitration.
    do_reset("rst3");
    apply("wd c0", mk(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA));
    apply("wd c1", mk(4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 32'hAAAA_AAAA));
    apply("wd c2", mk(4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA));
    apply("wd c3", mk(4'b0011, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 32'hAAAA_AAAA));
    apply("wd c4", mk(4'b0011, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 32'hAAAA_AAAA));
    apply("wd c5", mk(4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 32'h5555_5555));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
